// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry pipeline register slice (main + skid) with flush.
// Optional perf counters when PIPE_PERF_CNT_EN is defined.
module pipe_stage_elastic #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'hE000),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           out_pc,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [NUM_OPS*DATA_W-1:0] out_ops
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
`endif
);

  if (NUM_OPS < 1 || NUM_OPS > 4) begin : g_bad_num_ops
    $error("NUM_OPS must be 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be >= 1");
  end

  typedef struct packed {
    logic [PC_W-1:0]           pc;
    logic [INSTR_W-1:0]        instr;
    logic [NUM_OPS*DATA_W-1:0] ops;
  } entry_t;

  // State is {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  entry_t bubble;
  entry_t in_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_xfer;
  logic   out_xfer;

  assign bubble   = '{pc: '0, instr: NOP_INSTR, ops: '0};
  assign in_entry = '{pc: in_pc, instr: in_instr, ops: in_ops};

  assign in_xfer  = in_valid & ~skid_valid_q;
  assign out_xfer = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_d       = bubble;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
          end else if (out_xfer) begin
            main_d       = bubble;
            main_valid_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_d       = skid_q;
            skid_d       = '0;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_d       = bubble;
          skid_d       = '0;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= bubble;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Bubble payload is stored, so every output comes straight from a flop.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign out_ops   = main_q.ops;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!main_valid_q && out_ready && bubble_cnt_q != '1) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue model checked every cycle,
// plus directed literal checks.
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic [31:0] in_ops;
  logic [23:0] in_ops3;
  logic        out_ready;

  logic        out_valid, in_ready;
  logic [15:0] out_pc, out_instr;
  logic [31:0] out_ops;

  logic        out_valid3, in_ready3;
  logic [15:0] out_pc3, out_instr3;
  logic [23:0] out_ops3;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic        out_valid_s, in_ready_s;
  logic [15:0] out_pc_s, out_instr_s;
  logic [31:0] out_ops_s;
  logic [1:0]  stall_cnt_s, bubble_cnt_s;
  int stall_m, bubble_m, stall_sm, bubble_sm;
`endif

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [31:0] ops;
    logic [23:0] ops3;
  } ent_t;

  ent_t q[$];
  ent_t h;
  ent_t e;
  bit   ir_m;

  pipe_stage_elastic #(
    .PC_W(16), .INSTR_W(16), .DATA_W(16), .NUM_OPS(2),
    .NOP_INSTR(16'hE000), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_ops(out_ops)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_elastic #(
    .PC_W(16), .INSTR_W(16), .DATA_W(8), .NUM_OPS(3),
    .NOP_INSTR(16'hE000), .CNT_W(16)
  ) u_ops3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops3),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_pc(out_pc3), .out_instr(out_instr3), .out_ops(out_ops3)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(), .bubble_cnt()
`endif
  );

`ifdef PIPE_PERF_CNT_EN
  pipe_stage_elastic #(
    .PC_W(16), .INSTR_W(16), .DATA_W(16), .NUM_OPS(2),
    .NOP_INSTR(16'hE000), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_pc(out_pc_s), .out_instr(out_instr_s), .out_ops(out_ops_s),
    .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, x);
    end
  endtask

  // Model: occupancy queue; transfers decided from pre-edge state.
  always @(posedge clk) begin
    ir_m = (q.size() < 2);
    if (rst) begin
      q.delete();
      armed = 1;
`ifdef PIPE_PERF_CNT_EN
      stall_m = 0; bubble_m = 0; stall_sm = 0; bubble_sm = 0;
`endif
    end else begin
`ifdef PIPE_PERF_CNT_EN
      if (q.size() != 0 && !out_ready) begin
        if (stall_m < 65535) stall_m++;
        if (stall_sm < 3) stall_sm++;
      end
      if (q.size() == 0 && out_ready) begin
        if (bubble_m < 65535) bubble_m++;
        if (bubble_sm < 3) bubble_sm++;
      end
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && ir_m) begin
          e.pc = in_pc; e.instr = in_instr;
          e.ops = in_ops; e.ops3 = in_ops3;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (q.size() != 0) h = q[0];
      else begin
        h.pc = '0; h.instr = 16'hE000; h.ops = '0; h.ops3 = '0;
      end
      chk("m_valid", out_valid, q.size() != 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_pc", out_pc, h.pc);
      chk("m_instr", out_instr, h.instr);
      chk("m_ops", out_ops, h.ops);
      chk("m3_valid", out_valid3, q.size() != 0);
      chk("m3_in_ready", in_ready3, q.size() < 2);
      chk("m3_pc", out_pc3, h.pc);
      chk("m3_instr", out_instr3, h.instr);
      chk("m3_ops", out_ops3, h.ops3);
`ifdef PIPE_PERF_CNT_EN
      chk("ms_valid", out_valid_s, q.size() != 0);
      chk("ms_in_ready", in_ready_s, q.size() < 2);
      chk("ms_pc", out_pc_s, h.pc);
      chk("ms_instr", out_instr_s, h.instr);
      chk("ms_ops", out_ops_s, h.ops);
      chk("m_stall", stall_cnt, stall_m);
      chk("m_bubble", bubble_cnt, bubble_m);
      chk("ms_stall", stall_cnt_s, stall_sm);
      chk("ms_bubble", bubble_cnt_s, bubble_sm);
`endif
    end
  end

  task automatic step(input bit v, input logic [15:0] pc,
                      input bit ordy, input bit fl = 1'b0,
                      input bit r = 1'b0);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc ^ 16'h3C00;
    in_ops    = {pc + 16'h1111, ~pc};
    in_ops3   = (pc == 16'h0010) ? 24'hA1B2C3
                                 : {pc[7:0], 8'h5A, ~pc[7:0]};
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_ops = '0; in_ops3 = '0;
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 16'hE000);
    chk("rst_pc", out_pc, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ops3", out_ops3, 24'h0);

    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0010 + 16'(i), 1);
      chk("stream_pc", out_pc, 16'h0010 + 16'(i));
      chk("stream_in_ready", in_ready, 1'b1);
      if (i == 0) chk("ops3_pass", out_ops3, 24'hA1B2C3);
    end
    step(0, 16'h0, 1);
    chk("drain_valid", out_valid, 1'b0);

    step(1, 16'h0020, 0);
    chk("bp_first_ready", in_ready, 1'b1);
    step(1, 16'h0022, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_pc", out_pc, 16'h0020);
    step(0, 16'h0, 0);
    chk("bp_hold_pc", out_pc, 16'h0020);
    step(0, 16'h0, 1);
    chk("bp_pop_pc", out_pc, 16'h0022);
    chk("bp_pop_ready", in_ready, 1'b1);
    step(0, 16'h0, 1);
    chk("bp_empty", out_valid, 1'b0);

    step(1, 16'h0024, 0);
    step(1, 16'h0026, 0);
    chk("two_in_ready", in_ready, 1'b0);
    step(1, 16'h0030, 0, 1);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_instr", out_instr, 16'hE000);
    chk("fl_in_ready", in_ready, 1'b1);
    step(0, 16'h0, 1);
    chk("fl_no_0030", out_valid, 1'b0);

    step(1, 16'h0040, 1);
    step(1, 16'h0042, 1, 1);
    chk("fl_one_valid", out_valid, 1'b0);

    step(1, 16'h0044, 0);
    step(0, 16'h0, 0, 0, 1);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_pc", out_pc, 16'h0);

    step(1, 16'h0050, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0, 0);
    chk("stall_pc", out_pc, 16'h0050);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt5", stall_cnt, 16'd5);
    chk("stall_sat", stall_cnt_s, 2'd3);
`endif
    step(0, 16'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1);
`ifdef PIPE_PERF_CNT_EN
    chk("bubble_cnt3", bubble_cnt, 16'd3);
    chk("stall_kept", stall_cnt, 16'd5);
`endif
    chk("end_valid", out_valid, 1'b0);
    step(0, 16'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register. It is a two-entry register slice: one main entry plus one skid entry.
- Carries PC, instruction and NUM_OPS operand words between any two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM).
- Uses a valid/ready handshake, so back-pressure propagates upstream by one cycle without combinational ready paths.
- Synchronous flush inserts a NOP bubble.

Parameters:
- PC_W, 16, PC width in bits
- INSTR_W, 16, instruction width in bits
- DATA_W, 16, width of one operand word
- NUM_OPS, 2, number of operand words carried (1..4)
- NOP_INSTR, 16'hE000, instruction encoding driven when the stage holds a bubble
- CNT_W, 16, width of performance counters (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous flush; discards both entries
- in_valid  in  1  upstream presents a valid entry
- in_ready  out  1  slice can accept an entry this cycle
- in_pc  in  PC_W  upstream PC
- in_instr  in  INSTR_W  upstream instruction
- in_ops  in  NUM_OPS*DATA_W  operand words; op[k] is bits [k*DATA_W +: DATA_W]
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream consumes the entry this cycle
- out_pc  out  PC_W  PC of the head entry
- out_instr  out  INSTR_W  instruction of the head entry, NOP_INSTR when empty
- out_ops  out  NUM_OPS*DATA_W  operands of the head entry
- stall_cnt  out  CNT_W  present only with PIPE_PERF_CNT_EN
- bubble_cnt  out  CNT_W  present only with PIPE_PERF_CNT_EN

Behaviour:
- Single clock domain. rst is synchronous and active-high; it has priority over everything else.
- Reset values:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_ops=0
  - in_ready=1
  - skid entry cleared
  - counters=0
- Transfers:
  - Input transfer: in_valid & in_ready at the rising edge.
  - Output transfer: out_valid & out_ready at the rising edge.
- in_ready is a registered output, equal to NOT skid_valid. It never depends combinationally on out_ready.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0)
  - ONE (1,0)
  - TWO (1,1)
  - (0,1) is illegal and never reached.
- Transitions, with no flush:
  - EMPTY + in xfer -> ONE; main loads input.
  - ONE + in xfer + out xfer -> ONE; main loads input.
  - ONE + in xfer, no out xfer -> TWO; skid loads input, main holds.
  - ONE + out xfer, no in xfer -> EMPTY.
  - TWO + out xfer -> ONE; main loads skid. No input is accepted, because in_ready=0.
  - Otherwise, hold.
- Latency and throughput:
  - Latency: an entry accepted in cycle N is visible at the outputs in cycle N+1 if the slice was EMPTY, or ONE with an output transfer.
  - Sustained throughput: 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or rst.
- Output stability: while out_valid=1 and out_ready=0, out_pc, out_instr and out_ops hold constant.
- Bubble outputs: when out_valid=0, out_instr=NOP_INSTR, out_pc=0 and out_ops=0 (bubble, as seen by downstream decode).
- flush:
  - Next cycle: state EMPTY, bubble outputs, in_ready=1.
  - Any input presented in the flush cycle is discarded, even if in_ready was 1.
  - Any output transfer in that cycle still counts as consumed by downstream.
- flush while in TWO clears both entries in one cycle.
- rst mid-operation: identical effect to flush, and additionally clears the counters.
- Width rules: operand words are carried verbatim; there is no arithmetic on the datapath. NUM_OPS=1 must elaborate cleanly.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 & out_ready=1 (downstream starved).
  - Both counters saturate at all-ones and do not wrap.
  - rst clears both counters; flush does not.
- Undefined: stall_cnt and bubble_cnt ports and their logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then released -> out_valid=0, out_instr=16'hE000, out_pc=0, in_ready=1.
- Stream pc=0x0010..0x0013 with in_valid=1 and out_ready=1 -> out_pc follows 1 cycle later, 0x0010..0x0013 on consecutive cycles, in_ready stays 1.
- Push pc=0x0020 and 0x0022 with out_ready=0:
  - in_ready=0 after the second accept.
  - Outputs hold pc 0x0020.
  - Raise out_ready -> 0x0020 then 0x0022 appear, and in_ready=1 one cycle after the first pop.
- In TWO state, assert flush with in_valid=1, pc=0x0030 -> next cycle out_valid=0, out_instr=16'hE000, in_ready=1, and 0x0030 never appears.
- NUM_OPS=3, DATA_W=8, in_ops=24'hA1B2C3 -> out_ops=24'hA1B2C3 one cycle later.
- With PIPE_PERF_CNT_EN:
  - Hold out_ready=0 for 5 cycles with a valid entry -> stall_cnt=5.
  - Then 3 empty cycles with out_ready=1 -> bubble_cnt=3.
  - Saturation check with CNT_W=2: after 4 stalled cycles, stall_cnt stays at 3.
